// File: rtl/spi_slave_m.sv
// SPI mode-0 target: 8-bit MSB-first words, oversampled pins,
// single-entry TX buffer and multi-byte frames under one CS.
module spi_slave_m (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CS,
    input  logic       SCK,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [7:0] DOUT,
    input  logic       LOAD,
    output logic       READY,
    output logic [7:0] DIN,
    output logic       DONE,
    output logic       BUSY
);

    logic [2:0] cs_q;
    logic [2:0] sck_q;
    logic [1:0] mosi_q;

    logic [7:0] rx_sr_q, rx_sr_d;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic [7:0] tx_buf_q, tx_buf_d;
    logic [7:0] din_q, din_d;
    logic [2:0] cnt_q, cnt_d;
    logic       tx_full_q, tx_full_d;
    logic       done_q, done_d;

    logic cs_s, mosi_s;
    logic cs_fall, cs_rise;
    logic sck_rise, sck_fall;
    logic fetch;

    // Stage 2 is the synchronized value, stage 3 its previous sample.
    assign cs_s     = cs_q[1];
    assign mosi_s   = mosi_q[1];
    assign cs_fall  = ~cs_q[1] & cs_q[2];
    assign cs_rise  = cs_q[1] & ~cs_q[2];
    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];

    always_comb begin
        rx_sr_d   = rx_sr_q;
        tx_sr_d   = tx_sr_q;
        tx_buf_d  = tx_buf_q;
        din_d     = din_q;
        cnt_d     = cnt_q;
        tx_full_d = tx_full_q;
        done_d    = 1'b0;
        fetch     = 1'b0;

        if (cs_fall) begin
            cnt_d   = 3'd0;
            rx_sr_d = 8'h00;
            fetch   = 1'b1;
        end else if (cs_rise) begin
            cnt_d   = 3'd0;
            rx_sr_d = 8'h00;
            tx_sr_d = 8'h00;
        end else if (!cs_s) begin
            if (sck_rise) begin
                rx_sr_d = {rx_sr_q[6:0], mosi_s};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    din_d  = {rx_sr_q[6:0], mosi_s};
                    done_d = 1'b1;
                end
            end else if (sck_fall) begin
                if (cnt_q == 3'd0) begin
                    fetch = 1'b1;
                end else begin
                    tx_sr_d = {tx_sr_q[6:0], 1'b0};
                end
            end
        end

        // A fetch takes the old buffer contents; a same-cycle LOAD refills it.
        if (fetch) begin
            tx_sr_d   = tx_full_q ? tx_buf_q : 8'h00;
            tx_full_d = 1'b0;
        end
        if (LOAD) begin
            tx_buf_d  = DOUT;
            tx_full_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cs_q      <= 3'b111;
            sck_q     <= 3'b000;
            mosi_q    <= 2'b00;
            rx_sr_q   <= 8'h00;
            tx_sr_q   <= 8'h00;
            tx_buf_q  <= 8'h00;
            din_q     <= 8'h00;
            cnt_q     <= 3'd0;
            tx_full_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cs_q      <= {cs_q[1:0], CS};
            sck_q     <= {sck_q[1:0], SCK};
            mosi_q    <= {mosi_q[0], MOSI};
            rx_sr_q   <= rx_sr_d;
            tx_sr_q   <= tx_sr_d;
            tx_buf_q  <= tx_buf_d;
            din_q     <= din_d;
            cnt_q     <= cnt_d;
            tx_full_q <= tx_full_d;
            done_q    <= done_d;
        end
    end

    assign BUSY  = ~cs_s;
    assign MISO  = tx_sr_q[7] & BUSY;
    assign READY = ~tx_full_q;
    assign DIN   = din_q;
    assign DONE  = done_q;

endmodule

// File: tb/tb_spi_slave_m.sv
// Self-checking bench for spi_slave_m: a cycle-driven SPI master
// plus a byte-level model of what each side should receive.
module tb_spi_slave_m;

    logic       clk = 1'b0;
    logic       RST, CS, SCK, MOSI, LOAD;
    logic [7:0] DOUT;
    logic       MISO, READY, DONE, BUSY;
    logic [7:0] DIN;

    spi_slave_m dut (
        .CLK(clk), .RST(RST), .CS(CS), .SCK(SCK), .MOSI(MOSI),
        .MISO(MISO), .DOUT(DOUT), .LOAD(LOAD), .READY(READY),
        .DIN(DIN), .DONE(DONE), .BUSY(BUSY)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    int dbl = 0;
    int last_rise = 0;
    logic ready_s;
    logic done_prev = 1'b0;

    logic [7:0] mo_q[$];
    logic [7:0] tx_q[$];
    bit         ld_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] din_seen[$];
    int         done_cyc[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (DONE) begin
            din_seen.push_back(DIN);
            done_cyc.push_back(cyc);
            if (done_prev) dbl++;
        end
        done_prev = DONE;
    end

    task automatic do_load(input logic [7:0] v);
        @(negedge clk);
        LOAD = 1'b1;
        DOUT = v;
        @(negedge clk);
        LOAD = 1'b0;
    endtask

    // Master: MOSI changes on SCK fall, MISO sampled at SCK rise,
    // SCK half period 4 CLK. Stops after nrises rising edges.
    task automatic xfer(input int nrises, input bit same_ld,
                        input logic [7:0] same_val);
        logic [7:0] sh;
        int b;
        sh = 8'h00;
        rx_q.delete();
        din_seen.delete();
        done_cyc.delete();
        if (ld_q.size() > 0 && ld_q[0]) do_load(tx_q[0]);
        @(negedge clk);
        CS = 1'b0;
        MOSI = mo_q[0][7];
        if (same_ld) begin
            repeat (2) @(negedge clk);
            LOAD = 1'b1;
            DOUT = same_val;
            @(negedge clk);
            LOAD = 1'b0;
            ready_s = READY;
            @(negedge clk);
        end else begin
            repeat (4) @(negedge clk);
        end
        for (int j = 0; j < nrises; j++) begin
            b = j / 8;
            if (j == 0 && !same_ld) ready_s = READY;
            SCK = 1'b1;
            sh = {sh[6:0], MISO};
            last_rise = cyc;
            if (j % 8 == 7) rx_q.push_back(sh);
            if (j % 8 == 0 && b + 1 < mo_q.size() && ld_q[b+1]) begin
                LOAD = 1'b1;
                DOUT = tx_q[b+1];
                @(negedge clk);
                LOAD = 1'b0;
                repeat (3) @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            SCK = 1'b0;
            if (j + 1 < mo_q.size() * 8)
                MOSI = mo_q[(j+1)/8][7-((j+1)%8)];
            repeat (4) @(negedge clk);
        end
        CS = 1'b1;
        MOSI = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic set_frame(input logic [7:0] m0, input logic [7:0] t0,
                             input bit l0);
        mo_q.delete();
        tx_q.delete();
        ld_q.delete();
        mo_q.push_back(m0);
        tx_q.push_back(t0);
        ld_q.push_back(l0);
    endtask

    task automatic test_reset_state();
        vecs++;
        if ({DIN, DONE, MISO, READY, BUSY} !== {8'h00, 4'b0010}) begin
            errs++;
            $display("FAIL reset_state got DIN=%h DONE=%b MISO=%b READY=%b BUSY=%b",
                     DIN, DONE, MISO, READY, BUSY);
        end
    endtask

    task automatic test_single_byte();
        set_frame(8'h3C, 8'hA5, 1'b1);
        xfer(8, 1'b0, 8'h00);
        vecs++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
            errs++;
            $display("FAIL single_miso got %h want a5", rx_q.size() ? rx_q[0] : 8'hxx);
        end
        vecs++;
        if (din_seen.size() != 1 || din_seen[0] !== 8'h3C) begin
            errs++;
            $display("FAIL single_din got n=%0d want one 3c", din_seen.size());
        end
        vecs++;
        if (done_cyc.size() != 1 || done_cyc[0] != last_rise + 3) begin
            errs++;
            $display("FAIL single_done_time got %0d want %0d",
                     done_cyc.size() ? done_cyc[0] : -1, last_rise + 3);
        end
        vecs++;
        if (ready_s !== 1'b1) begin
            errs++;
            $display("FAIL single_ready got %b want 1", ready_s);
        end
        vecs++;
        if (DIN !== 8'h3C) begin
            errs++;
            $display("FAIL single_din_hold got %h want 3c", DIN);
        end
    endtask

    task automatic test_reset();
        do_load(8'h77);
        @(negedge clk);
        CS = 1'b0;
        MOSI = 1'b1;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            SCK = 1'b1;
            repeat (4) @(negedge clk);
            SCK = 1'b0;
            repeat (4) @(negedge clk);
        end
        RST = 1'b1;
        repeat (2) @(negedge clk);
        vecs++;
        if ({DIN, DONE, MISO, READY, BUSY} !== {8'h00, 4'b0010}) begin
            errs++;
            $display("FAIL midframe_reset got DIN=%h DONE=%b MISO=%b READY=%b BUSY=%b",
                     DIN, DONE, MISO, READY, BUSY);
        end
        RST = 1'b0;
        CS = 1'b1;
        MOSI = 1'b0;
        repeat (6) @(negedge clk);
        set_frame(8'hC3, 8'h96, 1'b1);
        xfer(8, 1'b0, 8'h00);
        vecs++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h96 || din_seen.size() != 1 ||
            din_seen[0] !== 8'hC3) begin
            errs++;
            $display("FAIL post_reset_frame got miso=%h din=%h want 96/c3",
                     rx_q.size() ? rx_q[0] : 8'hxx, DIN);
        end
    endtask

    task automatic test_multi_byte();
        set_frame(8'h81, 8'h11, 1'b1);
        mo_q.push_back(8'h7E);
        tx_q.push_back(8'h22);
        ld_q.push_back(1'b1);
        xfer(16, 1'b0, 8'h00);
        vecs++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'h11 || rx_q[1] !== 8'h22) begin
            errs++;
            $display("FAIL multi_miso got n=%0d want 11,22", rx_q.size());
        end
        vecs++;
        if (din_seen.size() != 2 || din_seen[0] !== 8'h81 || din_seen[1] !== 8'h7E) begin
            errs++;
            $display("FAIL multi_din got n=%0d want 81,7e", din_seen.size());
        end
    endtask

    task automatic test_underrun();
        set_frame(8'h5B, 8'hFF, 1'b0);
        xfer(8, 1'b0, 8'h00);
        vecs++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h00) begin
            errs++;
            $display("FAIL underrun_miso got %h want 00", rx_q.size() ? rx_q[0] : 8'hxx);
        end
        vecs++;
        if (din_seen.size() != 1 || din_seen[0] !== 8'h5B) begin
            errs++;
            $display("FAIL underrun_din got n=%0d want 5b", din_seen.size());
        end
    endtask

    task automatic test_abort();
        logic [7:0] prev;
        prev = DIN;
        set_frame(8'hAA, 8'h00, 1'b0);
        xfer(5, 1'b0, 8'h00);
        vecs++;
        if (din_seen.size() != 0 || DIN !== prev) begin
            errs++;
            $display("FAIL abort got dones=%0d DIN=%h want 0/%h", din_seen.size(), DIN, prev);
        end
        set_frame(8'hF0, 8'h00, 1'b0);
        xfer(8, 1'b0, 8'h00);
        vecs++;
        if (din_seen.size() != 1 || din_seen[0] !== 8'hF0) begin
            errs++;
            $display("FAIL after_abort got n=%0d DIN=%h want f0", din_seen.size(), DIN);
        end
    endtask

    task automatic test_deselected();
        int miso_hi;
        miso_hi = 0;
        din_seen.delete();
        MOSI = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            SCK = 1'b1;
            repeat (4) @(negedge clk);
            if (MISO !== 1'b0) miso_hi++;
            SCK = 1'b0;
            repeat (4) @(negedge clk);
        end
        MOSI = 1'b0;
        vecs++;
        if (din_seen.size() != 0 || miso_hi != 0) begin
            errs++;
            $display("FAIL deselected got dones=%0d miso_hi=%0d want 0/0",
                     din_seen.size(), miso_hi);
        end
        set_frame(8'h5A, 8'h00, 1'b0);
        xfer(8, 1'b0, 8'h00);
        vecs++;
        if (din_seen.size() != 1 || din_seen[0] !== 8'h5A) begin
            errs++;
            $display("FAIL deselected_next got n=%0d DIN=%h want 5a", din_seen.size(), DIN);
        end
    endtask

    task automatic test_fetch_load();
        set_frame(8'h12, 8'hC7, 1'b1);
        mo_q.push_back(8'h34);
        tx_q.push_back(8'h00);
        ld_q.push_back(1'b0);
        xfer(16, 1'b1, 8'h6D);
        vecs++;
        if (ready_s !== 1'b0) begin
            errs++;
            $display("FAIL fetch_load_ready got %b want 0", ready_s);
        end
        vecs++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'hC7 || rx_q[1] !== 8'h6D) begin
            errs++;
            $display("FAIL fetch_load_miso got n=%0d want c7,6d", rx_q.size());
        end
    endtask

    task automatic test_random();
        int n;
        logic [7:0] want;
        for (int f = 0; f < 20; f++) begin
            mo_q.delete();
            tx_q.delete();
            ld_q.delete();
            n = $urandom_range(3, 1);
            for (int b = 0; b < n; b++) begin
                mo_q.push_back(8'($urandom));
                tx_q.push_back(8'($urandom));
                ld_q.push_back($urandom_range(3, 0) != 0);
            end
            xfer(n * 8, 1'b0, 8'h00);
            for (int b = 0; b < n; b++) begin
                want = ld_q[b] ? tx_q[b] : 8'h00;
                vecs++;
                if (b >= rx_q.size() || rx_q[b] !== want) begin
                    errs++;
                    $display("FAIL rand_miso f%0d b%0d got %h want %h", f, b,
                             b < rx_q.size() ? rx_q[b] : 8'hxx, want);
                end
                vecs++;
                if (b >= din_seen.size() || din_seen[b] !== mo_q[b]) begin
                    errs++;
                    $display("FAIL rand_din f%0d b%0d got %h want %h", f, b,
                             b < din_seen.size() ? din_seen[b] : 8'hxx, mo_q[b]);
                end
            end
            vecs++;
            if (din_seen.size() != n) begin
                errs++;
                $display("FAIL rand_done_count f%0d got %0d want %0d", f, din_seen.size(), n);
            end
        end
    endtask

    task automatic test_done_width();
        vecs++;
        if (dbl != 0) begin
            errs++;
            $display("FAIL done_width got %0d multi-cycle pulses want 0", dbl);
        end
    endtask

    initial begin
        RST = 1'b1;
        CS = 1'b1;
        SCK = 1'b0;
        MOSI = 1'b0;
        LOAD = 1'b0;
        DOUT = 8'h00;
        repeat (3) @(negedge clk);
        test_reset_state();
        RST = 1'b0;
        repeat (4) @(negedge clk);
        test_single_byte();
        test_reset();
        test_multi_byte();
        test_underrun();
        test_abort();
        test_deselected();
        test_fetch_load();
        test_random();
        test_done_width();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/spi_slave_m.md
# spi_slave_m

SPI mode-0 responder (CPOL=0, CPHA=0), MSB first, 8-bit words. It is the target-side counterpart of the team's SPI master and sits between an external master's CS/SCK/MOSI/MISO pins and on-chip logic. It oversamples all SPI inputs on the system clock and returns each received byte on a parallel port with a one-cycle strobe. It shifts out a byte preloaded through a single-entry transmit buffer, and supports multi-byte frames under one CS assertion.

## Interface
Parameters: none; word width is fixed at 8.

- CLK  input  1  system clock; all state on rising edge
- RST  input  1  synchronous, active-high reset
- CS  input  1  chip select from master, active low, asynchronous to CLK
- SCK  input  1  serial clock from master, idle low, asynchronous to CLK
- MOSI  input  1  serial data from master
- MISO  output  1  serial data to master
- DOUT  input  8  byte to transmit; captured when LOAD=1
- LOAD  input  1  one-cycle strobe writing DOUT into the TX buffer
- READY  output  1  TX buffer empty; safe to LOAD
- DIN  output  8  last complete received byte; holds until the next byte completes
- DONE  output  1  one-cycle pulse when DIN updates
- BUSY  output  1  synchronized CS is low (frame in progress)

## Operation
- CS, SCK and MOSI each pass through 2-flop synchronizers. A third SCK/CS stage holds the previous value for edge detection. Rise and fall flags are combinational from stages 2 and 3.
- State: rx_sr[7:0], tx_sr[7:0], bit count cnt[2:0], tx_buf[7:0], tx_full.
- LOAD: tx_buf<=DOUT, tx_full<=1. LOAD while full overwrites. READY = !tx_full.
- TX buffer consumption ("fetch"): tx_sr<=tx_full ? tx_buf : 8'h00, and tx_full<=0. If the buffer is empty, 0x00 is sent. When a fetch and a LOAD occur in the same cycle, the fetch takes the old tx_buf and the LOAD wins: tx_buf=DOUT, tx_full=1.
- CS falling (synced): cnt<=0, rx_sr<=0, fetch.
- SCK rising while CS low: rx_sr<={rx_sr[6:0],MOSI_s}, cnt<=cnt+1, wrapping 7->0.
  - On the 8th rising edge (cnt==7): DIN<={rx_sr[6:0],MOSI_s}, DONE<=1.
- SCK falling while CS low:
  - cnt==0: fetch (byte boundary, loads the next word).
  - Otherwise: tx_sr<={tx_sr[6:0],1'b0}.
- MISO = tx_sr[7] & BUSY. MISO is driven low when deselected; the bus is single-slave and not tristated.
- CS rising (synced) mid-byte: abort. cnt<=0, partial rx_sr discarded, no DONE, DIN unchanged. The byte already in tx_sr is lost; tx_buf is untouched.
- Edges on SCK while CS is high are ignored.
- Rising and falling SCK edges cannot occur in the same CLK cycle, given the timing constraint below.
- CS falling and a SCK edge in the same cycle: the CS action wins and the SCK edge is ignored. The master guarantees at least one SCK half-period between CS falling and the first SCK rising edge.

## Timing
- Reset values: DIN=0, DONE=0, MISO=0, READY=1, BUSY=0, rx_sr=tx_sr=tx_buf=0, cnt=0.
  - Synchronizer stages reset to idle: CS=1, SCK=0, MOSI=0.
  - RST mid-frame aborts the frame identically.
- Input latency: a pin edge is acted on at the 3rd CLK rising edge after it, up to 1 cycle of sync uncertainty.
- DONE is high for exactly one cycle, starting 3 CLK edges after the 8th SCK rising edge at the pin. DIN is valid in that same cycle.
- MISO updates 3 CLK edges after SCK falls, and 3 CLK edges after CS falls for the first bit.
- Constraint: SCK high and low phases are each ≥4 CLK periods. This ensures MISO settles before the master's next sampling rising edge. It also makes MOSI, which changes on SCK falling, stable through synchronization at the rising edge.
- BUSY follows CS with 2-cycle latency.
- Back-to-back bytes: to avoid sending 0x00, LOAD the next word before the 8th SCK falling edge of the current byte minus 3 CLK cycles.

## Test plan
- Reset: assert RST 2 cycles mid-frame -> DIN=0, DONE=0, MISO=0, READY=1, BUSY=0. The next frame works normally.
- Single byte: LOAD 0xA5, master sends 0x3C with SCK at CLK/8 -> MISO bits 1,0,1,0,0,1,0,1 sampled on SCK rises. DIN=0x3C with one DONE pulse 3 CLK after the 8th rise. READY=1 after CS falls.
- Multi-byte frame: LOAD 0x11, then LOAD 0x22 after the first fetch. Master sends 0x81, 0x7E under one CS -> master receives 0x11, 0x22. DONE pulses twice, with DIN=0x81 then 0x7E.
- Underrun: no LOAD, one-byte frame -> master receives 0x00, DONE still pulses with the correct DIN.
- Abort: CS rises after 5 SCK rises -> no DONE, DIN keeps its prior value. Next frame of 0xF0 yields DIN=0xF0 with cnt restarted.
- Ignore when deselected: toggle SCK 8× with CS high -> no DONE, MISO=0, cnt stays 0. Same-cycle fetch+LOAD: READY=0 and tx_buf=new DOUT.
